// File: rtl/lsio_timer_cmp_if.sv
// Bus bundle for lsio_timer_cmp: control/programming inputs and timebase/compare outputs.
// The master side drives the programming signals; the slave side is the timer itself.
interface lsio_timer_cmp_if #(
    parameter int TIME_W = 32,
    parameter int N_CMP  = 4
);
    localparam int SEL_W = (N_CMP > 1) ? $clog2(N_CMP) : 1;

    logic              en_i;
    logic              time_we_i;
    logic [TIME_W-1:0] time_wdata_i;
    logic              cmp_we_i;
    logic [SEL_W-1:0]  cmp_sel_i;
    logic [TIME_W-1:0] cmp_wdata_i;
    logic [TIME_W-1:0] cmp_reload_i;
    logic [N_CMP-1:0]  cmp_disarm_i;
    logic [N_CMP-1:0]  irq_clr_i;
    logic [TIME_W-1:0] time_o;
    logic              tick_o;
    logic [N_CMP-1:0]  fire_o;
    logic [N_CMP-1:0]  irq_o;
    logic [N_CMP-1:0]  armed_o;

    modport master (
        output en_i, time_we_i, time_wdata_i, cmp_we_i, cmp_sel_i, cmp_wdata_i,
               cmp_reload_i, cmp_disarm_i, irq_clr_i,
        input  time_o, tick_o, fire_o, irq_o, armed_o
    );

    modport slave (
        input  en_i, time_we_i, time_wdata_i, cmp_we_i, cmp_sel_i, cmp_wdata_i,
               cmp_reload_i, cmp_disarm_i, irq_clr_i,
        output time_o, tick_o, fire_o, irq_o, armed_o
    );
endinterface

// File: rtl/lsio_timer_cmp.sv
// Low-speed timebase: prescaler-driven free-running time counter with N_CMP
// compare channels, each one-shot or auto-reload, raising sticky interrupts.
module lsio_timer_cmp #(
    parameter int FREQ    = 27000000,
    parameter int TICK_HZ = 1000,
    parameter int TIME_W  = 32,
    parameter int N_CMP   = 4
) (
    input logic                clk_i,
    input logic                rst_i,
    lsio_timer_cmp_if.slave    bus
);
    localparam int DIV   = FREQ / TICK_HZ;
    localparam int PW    = (DIV >= 2) ? $clog2(DIV) : 1;
    localparam int SEL_W = (N_CMP > 1) ? $clog2(N_CMP) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    if (DIV < 2 || TIME_W < 8 || TIME_W > 64 || N_CMP < 1 || N_CMP > 16) begin : gParamCheck
        $error("lsio_timer_cmp: DIV must be >= 2, TIME_W 8..64, N_CMP 1..16");
    end

    logic [PW-1:0]     presc_q, presc_d;
    logic [TIME_W-1:0] time_q, time_d;
    logic [TIME_W-1:0] target_q [N_CMP];
    logic [TIME_W-1:0] target_d [N_CMP];
    logic [TIME_W-1:0] reload_q [N_CMP];
    logic [TIME_W-1:0] reload_d [N_CMP];
    logic [N_CMP-1:0]  armed_q, armed_d;
    logic [N_CMP-1:0]  irq_q, irq_d;
    logic [N_CMP-1:0]  fire_q, fire_d;
    logic [N_CMP-1:0]  chWrite, match;
    logic              tick;

    assign tick = bus.en_i & (presc_q == PRESC_MAX);

    // A time load restarts the tick period and swallows any coincident increment.
    always_comb begin
        presc_d = presc_q;
        time_d  = time_q;
        if (bus.time_we_i) begin
            presc_d = '0;
            time_d  = bus.time_wdata_i;
        end else if (bus.en_i) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
                time_d = time_q + TIME_W'(1);
            end
        end
    end

    always_comb begin
        armed_d = armed_q;
        irq_d   = irq_q;
        fire_d  = '0;
        chWrite = '0;
        match   = '0;
        for (int i = 0; i < N_CMP; i++) begin
            target_d[i] = target_q[i];
            reload_d[i] = reload_q[i];
            chWrite[i]  = bus.cmp_we_i & (bus.cmp_sel_i == SEL_W'(i));
            match[i]    = armed_q[i] & (time_q == target_q[i]) & ~chWrite[i] & ~bus.cmp_disarm_i[i];
            if (chWrite[i]) begin
                target_d[i] = bus.cmp_wdata_i;
                reload_d[i] = bus.cmp_reload_i;
                armed_d[i]  = 1'b1;
            end
            // Disarm overrides a same-cycle programming write.
            if (bus.cmp_disarm_i[i]) begin
                armed_d[i] = 1'b0;
            end else if (match[i]) begin
                if (reload_q[i] == '0) begin
                    armed_d[i] = 1'b0;
                end else begin
                    target_d[i] = target_q[i] + reload_q[i];
                end
            end
            irq_d[i]  = match[i] | (irq_q[i] & ~bus.irq_clr_i[i]);
            fire_d[i] = match[i];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q <= '0;
            time_q  <= '0;
            armed_q <= '0;
            irq_q   <= '0;
            fire_q  <= '0;
            for (int i = 0; i < N_CMP; i++) begin
                target_q[i] <= '0;
                reload_q[i] <= '0;
            end
        end else begin
            presc_q <= presc_d;
            time_q  <= time_d;
            armed_q <= armed_d;
            irq_q   <= irq_d;
            fire_q  <= fire_d;
            for (int i = 0; i < N_CMP; i++) begin
                target_q[i] <= target_d[i];
                reload_q[i] <= reload_d[i];
            end
        end
    end

    assign bus.time_o  = time_q;
    assign bus.tick_o  = tick;
    assign bus.fire_o  = fire_q;
    assign bus.irq_o   = irq_q;
    assign bus.armed_o = armed_q;
endmodule

// File: tb/tb_lsio_timer_cmp.sv
// Directed bench for lsio_timer_cmp (DIV=10, TIME_W=8); expected compare fires are
// queued as {channel, time} when a channel is programmed and popped as fire_o pulses appear.
module tb_lsio_timer_cmp;
    localparam int TIME_W = 8;
    localparam int N_CMP  = 4;

    logic clk;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;
    logic [63:0] fireQ [$];

    lsio_timer_cmp_if #(.TIME_W(TIME_W), .N_CMP(N_CMP)) bus ();

    lsio_timer_cmp #(
        .FREQ(10), .TICK_HZ(1), .TIME_W(TIME_W), .N_CMP(N_CMP)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] fireKey(input int ch, input logic [TIME_W-1:0] tm);
        return (64'(ch) << 8) | 64'(tm);
    endfunction

    // Every fire_o pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_CMP; i++) begin
                if (bus.fire_o[i] === 1'b1) begin
                    if (fireQ.size() == 0)
                        checkOutput("fireUnexpected", fireKey(i, bus.time_o), 64'hFFFF_FFFF);
                    else
                        checkOutput("fireEvent", fireKey(i, bus.time_o), fireQ.pop_front());
                end
            end
        end
    end

    task automatic applyStimulus(input int sel, input logic [TIME_W-1:0] target,
                                 input logic [TIME_W-1:0] reload);
        bus.cmp_we_i     = 1'b1;
        bus.cmp_sel_i    = 2'(sel);
        bus.cmp_wdata_i  = target;
        bus.cmp_reload_i = reload;
        @(negedge clk);
        bus.cmp_we_i     = 1'b0;
    endtask

    task automatic applyTimeWrite(input logic [TIME_W-1:0] value);
        bus.time_we_i    = 1'b1;
        bus.time_wdata_i = value;
        @(negedge clk);
        bus.time_we_i    = 1'b0;
    endtask

    task automatic waitTime(input string tag, input logic [TIME_W-1:0] value, input int budget);
        int n = 0;
        while (bus.time_o !== value && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, bus.time_o, value);
    endtask

    task automatic waitTick(input string tag, input int budget, output int n);
        n = 0;
        while (bus.tick_o !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, bus.tick_o, 1'b1);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        bus.en_i         = 1'b1;
        bus.time_we_i    = 1'b0;
        bus.time_wdata_i = '0;
        bus.cmp_we_i     = 1'b0;
        bus.cmp_sel_i    = '0;
        bus.cmp_wdata_i  = '0;
        bus.cmp_reload_i = '0;
        bus.cmp_disarm_i = '0;
        bus.irq_clr_i    = '0;
        repeat (3) @(negedge clk);
        checkOutput("resetTime",  bus.time_o, 0);
        checkOutput("resetTick",  bus.tick_o, 0);
        checkOutput("resetFire",  bus.fire_o, 0);
        checkOutput("resetIrq",   bus.irq_o, 0);
        checkOutput("resetArmed", bus.armed_o, 0);
        rst = 1'b0;

        // Prescaler: first tick in the 10th enabled cycle, then every 10 cycles.
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            checkOutput($sformatf("tick1_%0d", k), bus.tick_o, (k == 9));
        end
        checkOutput("timeBeforeTick", bus.time_o, 0);
        @(negedge clk);
        checkOutput("timeAfterTick", bus.time_o, 1);
        checkOutput("tickPulseLow", bus.tick_o, 0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            checkOutput($sformatf("tick2_%0d", k), bus.tick_o, (k == 9));
        end

        // One-shot channel 0.
        fireQ.push_back(fireKey(0, 8'd5));
        applyStimulus(0, 8'd5, 8'd0);
        checkOutput("armed0", bus.armed_o[0], 1);
        waitTime("waitTime6", 8'd6, 200);
        checkOutput("oneShotIrq", bus.irq_o[0], 1);
        checkOutput("oneShotDisarmed", bus.armed_o[0], 0);
        bus.irq_clr_i = 4'b0001;
        @(negedge clk);
        bus.irq_clr_i = '0;
        checkOutput("irqCleared", bus.irq_o[0], 0);

        // Periodic channel 1 across the 8-bit wrap.
        fireQ.push_back(fireKey(1, 8'd250));
        fireQ.push_back(fireKey(1, 8'd4));
        fireQ.push_back(fireKey(1, 8'd14));
        applyStimulus(1, 8'd250, 8'd10);
        applyTimeWrite(8'd245);
        checkOutput("timeLoad245", bus.time_o, 245);
        waitTime("waitTime15", 8'd15, 500);
        checkOutput("periodicArmed", bus.armed_o[1], 1);
        bus.cmp_disarm_i = 4'b0010;
        @(negedge clk);
        bus.cmp_disarm_i = '0;
        checkOutput("disarm1", bus.armed_o[1], 0);

        // Time load during a tick cycle; channel 2 fires on the loaded value.
        fireQ.push_back(fireKey(2, 8'h40));
        applyStimulus(2, 8'h40, 8'd0);
        waitTick("tickBeforeLoad", 30, n);
        applyTimeWrite(8'h40);
        checkOutput("timeLoad40", bus.time_o, 8'h40);
        waitTick("tickAfterLoad", 30, n);
        checkOutput("tickGapAfterLoad", n, 9);
        checkOutput("timeStill40", bus.time_o, 8'h40);
        @(negedge clk);
        checkOutput("timeAfterLoadTick", bus.time_o, 8'h41);
        checkOutput("irq2", bus.irq_o[2], 1);

        // Clear coincident with a match: set wins.
        fireQ.push_back(fireKey(0, 8'h50));
        applyStimulus(0, 8'h50, 8'd0);
        waitTime("waitTime50", 8'h50, 300);
        checkOutput("irq0BeforeMatch", bus.irq_o[0], 0);
        bus.irq_clr_i = 4'b0001;
        @(negedge clk);
        bus.irq_clr_i = '0;
        checkOutput("setBeatsClear", bus.irq_o[0], 1);

        // Programming write on the match cycle suppresses that match.
        applyStimulus(3, 8'h52, 8'd0);
        waitTime("waitTime52", 8'h52, 100);
        fireQ.push_back(fireKey(3, 8'h60));
        applyStimulus(3, 8'h60, 8'd0);
        checkOutput("suppressedFire", bus.fire_o[3], 0);
        checkOutput("suppressedIrq", bus.irq_o[3], 0);
        checkOutput("rearmed3", bus.armed_o[3], 1);
        waitTime("waitTime61", 8'h61, 300);
        checkOutput("irq3", bus.irq_o[3], 1);

        // Build up state, then reset mid-operation.
        bus.irq_clr_i = 4'b1010;
        @(negedge clk);
        bus.irq_clr_i = '0;
        applyStimulus(1, 8'hF0, 8'd5);
        bus.cmp_disarm_i = 4'b0100;
        applyStimulus(2, 8'hF8, 8'd0);
        bus.cmp_disarm_i = '0;
        applyTimeWrite(8'd37);
        checkOutput("preResetTime", bus.time_o, 37);
        checkOutput("preResetIrq", bus.irq_o, 4'b0101);
        checkOutput("disarmBeatsWrite", bus.armed_o, 4'b0010);
        rst = 1'b1;
        #1;
        checkOutput("midResetTime",  bus.time_o, 0);
        checkOutput("midResetIrq",   bus.irq_o, 0);
        checkOutput("midResetArmed", bus.armed_o, 0);
        checkOutput("midResetTick",  bus.tick_o, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("postResetIrq",   bus.irq_o, 0);
        checkOutput("postResetArmed", bus.armed_o, 0);
        checkOutput("postResetTime",  bus.time_o, 0);
        checkOutput("scoreboardDrained", fireQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
